// File: rtl/scr1_tcm_loader_arb.sv
// scr1_tcm_loader_arb: packs a byte-stream boot image into TCM port B, then hands port B to the core.
// Optional SCR1_TCM_LOADER_RELOAD_EN: ld_valid while loaded restarts a fresh load from word 0.
module scr1_tcm_loader_arb #(
  parameter int SCR1_WIDTH = 32,
  parameter int SCR1_SIZE  = 32'h00010000,
  localparam int AW = $clog2(SCR1_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  core_rst_n_o,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [3:0]            core_be,
  input  logic [AW-3:0]         core_addr,
  input  logic [SCR1_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic [SCR1_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  output logic                  mem_renb,
  output logic                  mem_wenb,
  output logic [3:0]            mem_webb,
  output logic [AW-3:0]         mem_addrb,
  output logic [SCR1_WIDTH-1:0] mem_datab,
  input  logic [SCR1_WIDTH-1:0] mem_qb
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERR = 2'd3;
  logic [1:0]            state_q, state_d, cnt_q, cnt_d;
  logic [AW-2:0]         waddr_q, waddr_d;
  logic [23:0]           buf_q, buf_d;
  logic [SCR1_WIDTH-1:0] wdat_q, wdat_d, word;
  logic [3:0]            wbe_q, wbe_d;
  logic                  wpend_q, wpend_d, wlast_q, wlast_d, crst_q, rvalid_q;
  logic                  done, reload, accept, ovf;
  assign done = state_q == DONE;
`ifdef SCR1_TCM_LOADER_RELOAD_EN
  assign reload = done & ld_valid;
`else
  assign reload = 1'b0;
`endif
  // No new bytes while the final word is being written
  assign ld_ready = rst_n & ~done & ~wlast_q;
  assign accept   = ld_valid & ld_ready;
  // Top address bit marks the end of memory; also catch a byte arriving during the last-word write
  assign ovf  = waddr_q[AW-2] | (wpend_q & (&waddr_q[AW-3:0]));
  assign word = {8'h00, buf_q} | (SCR1_WIDTH'(ld_data) << {cnt_q, 3'b000});
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    buf_d   = buf_q;
    wdat_d  = wdat_q;
    wbe_d   = wbe_q;
    wpend_d = 1'b0;
    wlast_d = 1'b0;
    if (wpend_q) begin
      waddr_d = waddr_q + {{(AW-2){1'b0}}, 1'b1};
      if (wlast_q) state_d = DONE;
    end
    if (accept && state_q != ERR) begin
      if (ovf) state_d = ERR;
      else begin
        state_d = LOAD;
        if (cnt_q == 2'd3 || ld_last) begin
          wpend_d = 1'b1;
          wlast_d = ld_last;
          wdat_d  = word;
          wbe_d   = 4'((5'd2 << cnt_q) - 5'd1);
          cnt_d   = 2'd0;
          buf_d   = 24'h0;
        end else begin
          cnt_d = cnt_q + 2'd1;
          buf_d = word[23:0];
        end
      end
    end
    if (reload) begin
      state_d = IDLE;
      waddr_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      waddr_q  <= '0;
      buf_q    <= 24'h0;
      wdat_q   <= '0;
      wbe_q    <= 4'h0;
      wpend_q  <= 1'b0;
      wlast_q  <= 1'b0;
      crst_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      buf_q    <= buf_d;
      wdat_q   <= wdat_d;
      wbe_q    <= wbe_d;
      wpend_q  <= wpend_d;
      wlast_q  <= wlast_d;
      crst_q   <= done & ~reload;
      rvalid_q <= core_gnt & ~core_we;
    end
  end
  assign core_gnt     = done & ~reload & core_req;
  assign core_rdata   = mem_qb;
  assign core_rvalid  = rvalid_q;
  assign core_rst_n_o = crst_q;
  assign load_done    = done;
  assign load_err     = state_q == ERR;
  assign mem_renb     = core_gnt & ~core_we;
  assign mem_wenb     = done ? core_gnt & core_we : wpend_q;
  assign mem_webb     = done ? core_be : (wpend_q ? wbe_q : 4'h0);
  assign mem_addrb    = done ? core_addr : waddr_q[AW-3:0];
  assign mem_datab    = done ? core_wdata : wdat_q;
endmodule

// File: tb/tb_scr1_tcm_loader_arb.sv
// tb_scr1_tcm_loader_arb: directed checks of image packing, overflow, reset and core arbitration.
// Uses a 16-byte memory so the overflow boundary is reachable; honours SCR1_TCM_LOADER_RELOAD_EN.
module tb_scr1_tcm_loader_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, core_req = 1'b0, core_we = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic [3:0]  core_be = 4'h0;
  logic [1:0]  core_addr = 2'd0;
  logic [31:0] core_wdata = 32'h0;
  logic        ld_ready, load_done, load_err, core_rst_n_o, core_gnt, core_rvalid;
  logic        mem_renb, mem_wenb;
  logic [3:0]  mem_webb;
  logic [1:0]  mem_addrb;
  logic [31:0] core_rdata, mem_datab, mem_qb;
  logic [31:0] mem [4];
  logic [1:0]  wa [$];
  logic [31:0] wd [$];
  logic [3:0]  wb [$];
  int passed = 0, total = 0;

  scr1_tcm_loader_arb #(.SCR1_WIDTH(32), .SCR1_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .load_done(load_done), .load_err(load_err), .core_rst_n_o(core_rst_n_o),
    .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
    .core_rvalid(core_rvalid), .mem_renb(mem_renb), .mem_wenb(mem_wenb), .mem_webb(mem_webb),
    .mem_addrb(mem_addrb), .mem_datab(mem_datab), .mem_qb(mem_qb)
  );

  always #5 clk = ~clk;

  // Port-B memory with 1-cycle read latency, plus a log of every write
  always @(posedge clk) begin
    if (mem_wenb) begin
      for (int b = 0; b < 4; b++)
        if (mem_webb[b]) mem[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
      wa.push_back(mem_addrb);
      wd.push_back(mem_datab);
      wb.push_back(mem_webb);
    end
    if (mem_renb) mem_qb <= mem[mem_addrb];
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wb.delete();
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    core_req = 1'b0;
    core_we  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    bit ok = 1'b0;
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = ld_ready;
    end
    total++;
    if (!ok) $display("FAIL send_ready byte %h never accepted", b);
    else passed++;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ld_valid = 1'b1;
    core_req = 1'b1;
    #3;
    total++;
    if ({ld_ready, load_done, load_err, core_rst_n_o, core_gnt, core_rvalid, mem_renb, mem_wenb, mem_webb} !== 12'h0)
      $display("FAIL reset_outputs got %h exp 000", {ld_ready, load_done, load_err, core_rst_n_o, core_gnt, core_rvalid, mem_renb, mem_wenb, mem_webb});
    else passed++;
    ld_valid = 1'b0;
    do_reset();
    @(negedge clk);
    total++;
    if ({ld_ready, load_done, core_gnt} !== 3'b100) $display("FAIL idle_ready got %b exp 100", {ld_ready, load_done, core_gnt});
    else passed++;
  endtask

  task automatic test_load();
    logic [7:0] img [8] = '{8'h03, 8'h26, 8'h40, 8'h01, 8'h13, 8'h76, 8'h16, 8'h00};
    do_reset();
    for (int i = 0; i < 8; i++) send(img[i], i == 7);
    @(negedge clk);
    total++;
    if ({mem_wenb, mem_addrb, load_done} !== 4'b1010) $display("FAIL last_write got %b exp 1010", {mem_wenb, mem_addrb, load_done});
    else passed++;
    @(negedge clk);
    total++;
    if ({load_done, core_rst_n_o} !== 2'b10) $display("FAIL done_rise got %b exp 10", {load_done, core_rst_n_o});
    else passed++;
    @(negedge clk);
    total++;
    if ({load_done, core_rst_n_o} !== 2'b11) $display("FAIL core_release got %b exp 11", {load_done, core_rst_n_o});
    else passed++;
    total++;
    if (wa.size() != 2 || wa[0] !== 2'd0 || wa[1] !== 2'd1) $display("FAIL load_addrs got n=%0d exp 2 writes at 0,1", wa.size());
    else passed++;
    total++;
    if ({wd[0], wd[1], wb[0], wb[1]} !== {32'h01402603, 32'h00167613, 4'hF, 4'hF})
      $display("FAIL load_words got %h %h be %h %h exp 01402603 00167613 be f f", wd[0], wd[1], wb[0], wb[1]);
    else passed++;
  endtask

  task automatic test_core();
    @(posedge clk);
    #1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 2'd1;
    @(negedge clk);
    total++;
    if ({core_gnt, mem_renb, mem_wenb} !== 3'b110) $display("FAIL core_read_gnt got %b exp 110", {core_gnt, mem_renb, mem_wenb});
    else passed++;
    @(posedge clk);
    #1;
    core_we    = 1'b1;
    core_be    = 4'h2;
    core_wdata = 32'h0000FF00;
    @(negedge clk);
    total++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'h00167613}) $display("FAIL core_read got %b %h exp 1 00167613", core_rvalid, core_rdata);
    else passed++;
    total++;
    if ({core_gnt, mem_wenb, mem_webb} !== 6'b110010) $display("FAIL core_write got %b exp 110010", {core_gnt, mem_wenb, mem_webb});
    else passed++;
    @(posedge clk);
    #1;
    core_we = 1'b0;
    @(negedge clk);
    total++;
    if (core_rvalid !== 1'b0) $display("FAIL write_no_rvalid got %b exp 0", core_rvalid);
    else passed++;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    @(negedge clk);
    total++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'h0016FF13}) $display("FAIL read_after_write got %b %h exp 1 0016ff13", core_rvalid, core_rdata);
    else passed++;
  endtask

  task automatic test_partial();
    logic [7:0] img [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_reset();
    for (int i = 0; i < 5; i++) send(img[i], i == 4);
    repeat (3) @(negedge clk);
    total++;
    if (wa.size() != 2 || {wd[0], wb[0]} !== {32'hDDCCBBAA, 4'hF}) $display("FAIL partial_word0 got n=%0d %h be %h exp 2 ddccbbaa be f", wa.size(), wd[0], wb[0]);
    else passed++;
    total++;
    if ({wa[1], wd[1][7:0], wb[1]} !== {2'd1, 8'hEE, 4'h1}) $display("FAIL partial_word1 got a%0d %h be %h exp a1 ee be 1", wa[1], wd[1][7:0], wb[1]);
    else passed++;
    total++;
    if ({load_done, load_err} !== 2'b10) $display("FAIL partial_done got %b exp 10", {load_done, load_err});
    else passed++;
  endtask

  task automatic test_exact_fill();
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), i == 15);
    repeat (3) @(negedge clk);
    total++;
    if ({32'(wa.size()), load_done, load_err} !== {32'd4, 2'b10}) $display("FAIL exact_fill got n=%0d done %b err %b exp 4 1 0", wa.size(), load_done, load_err);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(i), 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() != 4 || wd[3] !== 32'h0F0E0D0C) $display("FAIL ovf_writes got n=%0d last %h exp 4 0f0e0d0c", wa.size(), wd[3]);
    else passed++;
    total++;
    if ({load_err, load_done, core_rst_n_o, ld_ready, mem_wenb} !== 5'b10010) $display("FAIL ovf_state got %b exp 10010", {load_err, load_done, core_rst_n_o, ld_ready, mem_wenb});
    else passed++;
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
    rst_n = 1'b0;
    #2;
    total++;
    if ({ld_ready, mem_wenb, mem_webb, load_done, core_rst_n_o} !== 8'h0) $display("FAIL midreset_outputs got %b exp 0", {ld_ready, mem_wenb, mem_webb, load_done, core_rst_n_o});
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() != 1) $display("FAIL midreset_no_partial got n=%0d exp 1", wa.size());
    else passed++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() != 1 || {wa[0], wd[0], wb[0]} !== {2'd0, 32'h44332211, 4'hF}) $display("FAIL midreset_reload got n=%0d a%0d %h exp 1 a0 44332211", wa.size(), wa[0], wd[0]);
    else passed++;
  endtask

`ifdef SCR1_TCM_LOADER_RELOAD_EN
  task automatic test_done_ld();
    clear_log();
    ld_valid = 1'b1;
    ld_data  = 8'h5A;
    core_req = 1'b1;
    core_we  = 1'b0;
    @(negedge clk);
    total++;
    if ({ld_ready, core_gnt, mem_renb} !== 3'b000) $display("FAIL reload_trigger got %b exp 000", {ld_ready, core_gnt, mem_renb});
    else passed++;
    @(posedge clk);
    #1;
    core_req = 1'b0;
    @(negedge clk);
    total++;
    if ({load_done, core_rst_n_o, ld_ready} !== 3'b001) $display("FAIL reload_idle got %b exp 001", {load_done, core_rst_n_o, ld_ready});
    else passed++;
    @(posedge clk);
    #1;
    send(8'h6B, 1'b0);
    send(8'h7C, 1'b0);
    send(8'h8D, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (wa.size() != 1 || {wa[0], wd[0]} !== {2'd0, 32'h8D7C6B5A}) $display("FAIL reload_word got n=%0d a%0d %h exp 1 a0 8d7c6b5a", wa.size(), wa[0], wd[0]);
    else passed++;
  endtask
`else
  task automatic test_done_ld();
    ld_valid  = 1'b1;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 2'd0;
    @(negedge clk);
    total++;
    if ({ld_ready, core_gnt} !== 2'b01) $display("FAIL done_ignore_ld got %b exp 01", {ld_ready, core_gnt});
    else passed++;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    core_req = 1'b0;
    @(negedge clk);
    total++;
    if ({load_done, core_rst_n_o, core_rvalid} !== 3'b111) $display("FAIL done_terminal got %b exp 111", {load_done, core_rst_n_o, core_rvalid});
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_core();
    test_done_ld();
    test_partial();
    test_exact_fill();
    test_overflow();
    test_midreset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end
endmodule
